// File: rtl/gpu_compositor_pkg.sv
// Shared constants and types for the GPU pixel compositor: VRAM control-register
// offsets, mode bit positions and the per-frame control record.
package gpu_compositor_pkg;

    localparam int VRAM_ADDR_WIDTH = 16;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_BACKDROP = 1;
    localparam int CTRL_MODE     = 2;

    localparam int MODE_FORCE_BLANK = 0;
    localparam int MODE_REVERSE     = 1;

    typedef struct packed {
        logic [7:0] mask;
        logic [7:0] backdrop;
        logic       reverse;
        logic       force_blank;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{mask: 8'hFF, backdrop: 8'h00, reverse: 1'b0, force_blank: 1'b0};

    // Signals that travel alongside the layer fetch so they meet the layer data.
    typedef struct packed {
        logic drawing;
        logic hsync;
        logic vsync;
    } align_t;

    localparam align_t ALIGN_RESET = '{drawing: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/gpu_priority_mux_m.sv
// Combinational layer priority mux: lowest valid index wins, or the highest
// valid index when reverse is set.
module gpu_priority_mux_m #(
    parameter int NUM_LAYERS = 2,
    parameter int PIX_BITS   = 6
) (
    input  logic [NUM_LAYERS-1:0]          valid,
    input  logic [NUM_LAYERS*PIX_BITS-1:0] rgb,
    input  logic                           reverse,
    output logic                           hit,
    output logic [PIX_BITS-1:0]            pixel
);

    always_comb begin
        // NOTE: every output gets a default before the loops, so no path leaves it unassigned and no latch is inferred.
        hit   = |valid;
        pixel = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (!reverse && valid[i]) pixel = rgb[i*PIX_BITS +: PIX_BITS];
        end
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (reverse && valid[i]) pixel = rgb[i*PIX_BITS +: PIX_BITS];
        end
    end

endmodule

// File: rtl/gpu_compositor_m.sv
// Pixel compositor: derives layer coordinates, delays window/sync flags to meet
// the layer data, and mixes layers over a backdrop under double-buffered control.
module gpu_compositor_m
    import gpu_compositor_pkg::*;
#(
    parameter int                         NUM_LAYERS    = 2,
    parameter int                         COLOR_BITS    = 2,
    parameter int                         H_OFFSET      = 32,
    parameter int                         ACTIVE_W      = 256,
    parameter int                         ACTIVE_H      = 240,
    parameter int                         Y_SHIFT       = 1,
    parameter int                         LAYER_LATENCY = 1,
    parameter logic [VRAM_ADDR_WIDTH-1:0] CTRL_BASE     = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [9:0]                         hcounter,
    input  logic [9:0]                         vcounter,
    input  logic                               visible,
    input  logic                               writable,
    input  logic                               hsync_in,
    input  logic                               vsync_in,
    input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]              layer_valid,
    input  logic [7:0]                         data,
    input  logic [VRAM_ADDR_WIDTH-1:0]         address,
    output logic [7:0]                         xp,
    output logic [7:0]                         yp,
    output logic [COLOR_BITS-1:0]              r,
    output logic [COLOR_BITS-1:0]              g,
    output logic [COLOR_BITS-1:0]              b,
    output logic                               hsync,
    output logic                               vsync
);

    localparam int PIX_BITS = 3 * COLOR_BITS;

    logic [8:0] xp9;
    logic [8:0] yp9;
    align_t     stage0;
    align_t     aligned;

    // hcounter below H_OFFSET wraps xp9 to 256 or more, which the compare rejects.
    assign xp9    = hcounter[8:0] - 9'(H_OFFSET);
    assign yp9    = 9'(vcounter >> Y_SHIFT);
    assign xp     = xp9[7:0];
    assign yp     = yp9[7:0];
    assign stage0 = '{drawing: visible && ({1'b0, xp9} < 10'(ACTIVE_W)) && ({1'b0, yp9} < 10'(ACTIVE_H)),
                      hsync:   hsync_in,
                      vsync:   vsync_in};

    generate
        if (LAYER_LATENCY == 0) begin : g_no_delay
            assign aligned = stage0;
        end else begin : g_delay
            align_t sr [LAYER_LATENCY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAYER_LATENCY; i++) sr[i] <= ALIGN_RESET;
                end else begin
                    // NOTE: non-blocking so each stage takes its neighbour's previous value; blocking would collapse the chain.
                    sr[0] <= stage0;
                    for (int i = 1; i < LAYER_LATENCY; i++) sr[i] <= sr[i-1];
                end
            end

            assign aligned = sr[LAYER_LATENCY-1];
        end
    endgenerate

    ctrl_t shadow;
    ctrl_t active;
    logic  writable_q;
    logic  transfer;

    assign transfer = writable_q && !writable;

    // Writes land in the shadow set; the active set only changes as a new frame starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= CTRL_RESET;
            active     <= CTRL_RESET;
            writable_q <= 1'b0;
        end else begin
            writable_q <= writable;
            if (transfer) active <= shadow;
            if (writable) begin
                if (address == CTRL_BASE + VRAM_ADDR_WIDTH'(CTRL_ENABLE))   shadow.mask     <= data;
                if (address == CTRL_BASE + VRAM_ADDR_WIDTH'(CTRL_BACKDROP)) shadow.backdrop <= data;
                if (address == CTRL_BASE + VRAM_ADDR_WIDTH'(CTRL_MODE)) begin
                    shadow.force_blank <= data[MODE_FORCE_BLANK];
                    shadow.reverse     <= data[MODE_REVERSE];
                end
            end
        end
    end

    logic [NUM_LAYERS-1:0] eff_valid;
    logic                  hit;
    logic [PIX_BITS-1:0]   winner;
    logic [PIX_BITS-1:0]   mix_pixel;

    assign eff_valid = layer_valid & active.mask[NUM_LAYERS-1:0];

    gpu_priority_mux_m #(
        .NUM_LAYERS (NUM_LAYERS),
        .PIX_BITS   (PIX_BITS)
    ) u_priority_mux (
        .valid   (eff_valid),
        .rgb     (layer_rgb),
        .reverse (active.reverse),
        .hit     (hit),
        .pixel   (winner)
    );

    always_comb begin
        mix_pixel = '0;
        if (aligned.drawing && !active.force_blank) begin
            mix_pixel = hit ? winner : active.backdrop[PIX_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {r, g, b} <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            {r, g, b} <= mix_pixel;
            hsync     <= aligned.hsync;
            vsync     <= aligned.vsync;
        end
    end

endmodule

// File: tb/tb_gpu_compositor_m.sv
// Self-checking bench for gpu_compositor_m: directed scenarios plus a randomized
// run compared against a cycle-indexed behavioural model of frames and layers.
module tb_gpu_compositor_m;

    localparam int LAT = 1;
    localparam int NL  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcounter, vcounter;
    logic        visible, writable, hsync_in, vsync_in;
    logic [11:0] layer_rgb;
    logic [1:0]  layer_valid;
    logic [7:0]  data;
    logic [15:0] address;
    logic [7:0]  xp, yp;
    logic [1:0]  r, g, b;
    logic        hsync, vsync;

    always #5 clk = ~clk;

    gpu_compositor_m dut (
        .clk(clk), .rst(rst), .hcounter(hcounter), .vcounter(vcounter),
        .visible(visible), .writable(writable), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .layer_rgb(layer_rgb), .layer_valid(layer_valid), .data(data), .address(address),
        .xp(xp), .yp(yp), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic [9:0]  hc, vc;
        logic        vis, wr, hs, vs;
        logic [11:0] lrgb;
        logic [1:0]  lval;
        logic [7:0]  data;
        logic [15:0] addr;
    } stim_t;

    stim_t hist[$];
    int    last_rst_idx = 0;

    // Model state: settings written this frame, and settings in force.
    logic [7:0] sh_mask = 8'hFF, act_mask = 8'hFF;
    logic [7:0] sh_bd = 8'h00, act_bd = 8'h00;
    logic [1:0] sh_mode = 2'b00, act_mode = 2'b00;
    logic       prev_wr = 1'b0;
    logic [5:0] exp_rgb;
    logic       exp_hs, exp_vs;

    function automatic bit in_window(stim_t s);
        int x = ((int'(s.hc) % 512) - 32 + 512) % 512;
        int y = int'(s.vc) / 2;
        return s.vis && x < 256 && y < 240;
    endfunction

    function automatic logic [5:0] pick_pixel(stim_t s, logic [7:0] mask, logic [7:0] bd, logic [1:0] mode);
        int w = -1;
        for (int i = 0; i < NL; i++)
            if (s.lval[i] && mask[i] && (w < 0 || mode[1])) w = i;
        if (w < 0) return bd[5:0];
        return s.lrgb[w*6 +: 6];
    endfunction

    // One clock: record the driven inputs, advance, and predict the outputs now visible.
    task automatic tick();
        stim_t s, c;
        int n;
        s = '{rst: rst, hc: hcounter, vc: vcounter, vis: visible, wr: writable, hs: hsync_in,
              vs: vsync_in, lrgb: layer_rgb, lval: layer_valid, data: data, addr: address};
        hist.push_back(s);
        n = hist.size() - 1;
        @(posedge clk);
        #1;
        if (s.rst) begin
            last_rst_idx = n;
            exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1;
            sh_mask = 8'hFF; act_mask = 8'hFF; sh_bd = '0; act_bd = '0;
            sh_mode = '0; act_mode = '0; prev_wr = 1'b0;
        end else begin
            if (n - last_rst_idx <= LAT) begin
                exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1;
            end else begin
                c = hist[n-LAT];
                exp_hs = c.hs;
                exp_vs = c.vs;
                exp_rgb = (!in_window(c) || act_mode[0]) ? 6'd0 : pick_pixel(s, act_mask, act_bd, act_mode);
            end
            if (prev_wr && !s.wr) begin
                act_mask = sh_mask; act_bd = sh_bd; act_mode = sh_mode;
            end
            if (s.wr) begin
                if (s.addr == 16'd0) sh_mask = s.data;
                if (s.addr == 16'd1) sh_bd = s.data;
                if (s.addr == 16'd2) sh_mode = s.data[1:0];
            end
            prev_wr = s.wr;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic frame_write(input logic [15:0] a, input logic [7:0] d);
        writable = 1'b1; address = a; data = d;
        tick();
        address = 16'hFFFF;
        tick();
        writable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; visible = 1'b1; hcounter = 10'd100; vcounter = 10'd20;
        layer_valid = 2'b01; layer_rgb = {6'b000000, 6'b110000};
        repeat (3) begin
            tick();
            n_cmp++;
            if ({r, g, b, hsync, vsync} !== 8'b000000_11) begin
                n_err++;
                $display("FAIL reset_state: got rgb=%b hs=%b vs=%b want rgb=000000 hs=1 vs=1", {r, g, b}, hsync, vsync);
            end
        end
        rst = 1'b0; hcounter = 10'd32; vcounter = 10'd0;
        #1;
        n_cmp++;
        if ({xp, yp} !== 16'h0000) begin
            n_err++;
            $display("FAIL origin_coords: got xp=%0d yp=%0d want 0 0", xp, yp);
        end
        tick();
        n_cmp++;
        if ({r, g, b} !== 6'b000000) begin
            n_err++;
            $display("FAIL release_idle: got %b want 000000", {r, g, b});
        end
        tick();
        n_cmp++;
        if ({r, g, b} !== 6'b110000) begin
            n_err++;
            $display("FAIL first_pixel: got %b want 110000", {r, g, b});
        end
    endtask

    task automatic test_priority();
        hcounter = 10'd100; vcounter = 10'd40;
        layer_valid = 2'b11; layer_rgb = {6'b000011, 6'b110000};
        settle(2);
        n_cmp++;
        if ({r, g, b} !== 6'b110000) begin
            n_err++;
            $display("FAIL fixed_priority: got %b want 110000", {r, g, b});
        end
        writable = 1'b1; address = 16'd2; data = 8'h02;
        tick();
        address = 16'hFFFF;
        settle(2);
        n_cmp++;
        if ({r, g, b} !== 6'b110000) begin
            n_err++;
            $display("FAIL mode_held_in_shadow: got %b want 110000", {r, g, b});
        end
        writable = 1'b0;
        settle(3);
        n_cmp++;
        if ({r, g, b} !== 6'b000011) begin
            n_err++;
            $display("FAIL reverse_priority: got %b want 000011", {r, g, b});
        end
    endtask

    task automatic test_backdrop_window();
        logic [9:0] hc_tab [6] = '{10'd100, 10'd288, 10'd287, 10'd100, 10'd31, 10'd32};
        logic [9:0] vc_tab [6] = '{10'd10,  10'd10,  10'd479, 10'd480, 10'd0,  10'd0};
        logic [5:0] want   [6] = '{6'b010101, 6'b000000, 6'b010101, 6'b000000, 6'b000000, 6'b010101};
        layer_valid = 2'b00; hcounter = 10'd100; vcounter = 10'd10;
        writable = 1'b1; address = 16'd1; data = 8'h15;
        tick();
        address = 16'hFFFF;
        settle(2);
        n_cmp++;
        if ({r, g, b} !== 6'b000000) begin
            n_err++;
            $display("FAIL backdrop_held_in_shadow: got %b want 000000", {r, g, b});
        end
        writable = 1'b0;
        settle(1);
        for (int i = 0; i < 6; i++) begin
            hcounter = hc_tab[i]; vcounter = vc_tab[i];
            settle(LAT + 1);
            n_cmp++;
            if ({r, g, b} !== want[i]) begin
                n_err++;
                $display("FAIL window_edge hc=%0d vc=%0d: got %b want %b", hc_tab[i], vc_tab[i], {r, g, b}, want[i]);
            end
        end
        visible = 1'b0;
        settle(LAT + 1);
        n_cmp++;
        if ({r, g, b} !== 6'b000000) begin
            n_err++;
            $display("FAIL not_visible: got %b want 000000", {r, g, b});
        end
        visible = 1'b1;
    endtask

    task automatic test_write_gate();
        hcounter = 10'd100; vcounter = 10'd10;
        layer_valid = 2'b01; layer_rgb = {6'b000011, 6'b110000};
        writable = 1'b0; address = 16'd0; data = 8'h00;
        tick();
        address = 16'hFFFF;
        writable = 1'b1;
        tick();
        writable = 1'b0;
        settle(3);
        n_cmp++;
        if ({r, g, b} !== 6'b110000) begin
            n_err++;
            $display("FAIL write_outside_window: got %b want 110000", {r, g, b});
        end
        writable = 1'b1; address = 16'd0; data = 8'h00;
        tick();
        address = 16'h0101; data = 8'h3F;
        tick();
        address = 16'hFFFF; writable = 1'b0;
        settle(3);
        n_cmp++;
        if ({r, g, b} !== 6'b010101) begin
            n_err++;
            $display("FAIL mask_zero_or_alias: got %b want 010101", {r, g, b});
        end
        frame_write(16'd0, 8'hFC);
        settle(2);
        n_cmp++;
        if ({r, g, b} !== 6'b010101) begin
            n_err++;
            $display("FAIL mask_upper_bits: got %b want 010101", {r, g, b});
        end
        frame_write(16'd0, 8'h02);
        layer_valid = 2'b11;
        settle(2);
        n_cmp++;
        if ({r, g, b} !== 6'b000011) begin
            n_err++;
            $display("FAIL mask_layer1_only: got %b want 000011", {r, g, b});
        end
        frame_write(16'd0, 8'hFF);
        frame_write(16'd2, 8'h00);
    endtask

    task automatic test_sync_align();
        int lows = 0;
        int first = -1;
        layer_valid = 2'b01; layer_rgb = {6'b000011, 6'b110000};
        hcounter = 10'd100; vcounter = 10'd10;
        visible = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        settle(3);
        for (int i = 0; i < 110; i++) begin
            hsync_in = (i < 96) ? 1'b0 : 1'b1;
            visible  = (i < 96);
            tick();
            if (hsync == 1'b0) begin
                lows++;
                if (first < 0) first = i;
            end
            n_cmp++;
            if ((hsync == 1'b0) !== ({r, g, b} != 6'b000000)) begin
                n_err++;
                $display("FAIL sync_lockstep i=%0d: got hs=%b rgb=%b want marker while hs low", i, hsync, {r, g, b});
            end
            n_cmp++;
            if ({r, g, b, hsync, vsync} !== {exp_rgb, exp_hs, exp_vs}) begin
                n_err++;
                $display("FAIL sync_model i=%0d: got %b want %b", i, {r, g, b, hsync, vsync}, {exp_rgb, exp_hs, exp_vs});
            end
        end
        n_cmp++;
        if (lows !== 96) begin
            n_err++;
            $display("FAIL hsync_width: got %0d want 96", lows);
        end
        n_cmp++;
        if (first !== LAT) begin
            n_err++;
            $display("FAIL hsync_delay: first low after tick %0d want %0d", first, LAT);
        end
        visible = 1'b1;
    endtask

    task automatic test_force_blank_and_reset();
        frame_write(16'd2, 8'h01);
        settle(2);
        for (int i = 0; i < 60; i++) begin
            hcounter = 10'($urandom_range(32, 287)); vcounter = 10'($urandom_range(0, 479));
            layer_valid = 2'($urandom); layer_rgb = 12'($urandom);
            hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            tick();
            n_cmp++;
            if ({r, g, b, hsync, vsync} !== {6'b000000, exp_hs, exp_vs}) begin
                n_err++;
                $display("FAIL force_blank i=%0d: got %b want %b", i, {r, g, b, hsync, vsync}, {6'b000000, exp_hs, exp_vs});
            end
        end
        hcounter = 10'd100; vcounter = 10'd10; hsync_in = 1'b0; vsync_in = 1'b0;
        layer_valid = 2'b01; layer_rgb = {6'b000011, 6'b110000};
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({r, g, b, hsync, vsync} !== 8'b000000_11) begin
            n_err++;
            $display("FAIL midline_reset: got %b want 00000011", {r, g, b, hsync, vsync});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({r, g, b, hsync} !== 7'b000000_1) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b want 0000001", {r, g, b, hsync});
        end
        tick();
        n_cmp++;
        if ({r, g, b, hsync} !== 7'b110000_0) begin
            n_err++;
            $display("FAIL post_reset_first: got %b want 1100000", {r, g, b, hsync});
        end
        hsync_in = 1'b1; vsync_in = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] addr_tab [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'h0102};
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 499) == 0);
            writable    = ((i % 200) >= 180);
            address     = addr_tab[$urandom_range(0, 4)];
            data        = 8'($urandom);
            hcounter    = 10'($urandom_range(0, 799));
            vcounter    = 10'($urandom_range(0, 524));
            visible     = ($urandom_range(0, 7) != 0);
            hsync_in    = ($urandom_range(0, 3) != 0);
            vsync_in    = ($urandom_range(0, 3) != 0);
            layer_valid = 2'($urandom);
            layer_rgb   = 12'($urandom);
            #1;
            n_cmp++;
            if ({xp, yp} !== {8'((int'(hcounter) - 32 + 512) % 256), 8'((int'(vcounter) / 2) % 256)}) begin
                n_err++;
                $display("FAIL rand_coords i=%0d hc=%0d vc=%0d: got xp=%0d yp=%0d", i, hcounter, vcounter, xp, yp);
            end
            tick();
            n_cmp++;
            if ({r, g, b, hsync, vsync} !== {exp_rgb, exp_hs, exp_vs}) begin
                n_err++;
                $display("FAIL rand_output i=%0d: got %b want %b", i, {r, g, b, hsync, vsync}, {exp_rgb, exp_hs, exp_vs});
            end
        end
        rst = 1'b0; writable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hcounter = '0; vcounter = '0; visible = 1'b1; writable = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; layer_rgb = '0; layer_valid = '0;
        data = '0; address = 16'hFFFF;
        @(posedge clk);
        #1;
        test_reset();
        test_priority();
        test_backdrop_window();
        test_write_gate();
        test_sync_align();
        test_force_blank_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
